// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback scheduler.
package rf_pkg;
  localparam int RF_DW    = 16;
  localparam int RF_AW    = 3;
  localparam int RF_NREGS = 8;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant advances only when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_grant;

  // On contention favour the requester that did not win last time.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset)        last_grant <= 1'b1;
    else if (advance) last_grant <= gnt[1];
  end
endmodule

// File: rtl/rf_wb_sched.sv
// Writeback port sharing, pending-write scoreboard and issue hazard stall
// in front of the register file.
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int NREGS = RF_NREGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_dst,
  input  logic [AW-1:0]    issue_src_a,
  input  logic [AW-1:0]    issue_src_b,
  output logic             issue_ready,
  input  logic             wb0_valid,
  input  logic [AW-1:0]    wb0_addr,
  input  logic [DW-1:0]    wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [AW-1:0]    wb1_addr,
  input  logic [DW-1:0]    wb1_data,
  output logic             wb1_ready,
  output logic             rf_wr,
  output logic [AW-1:0]    rf_wr_addr,
  output logic [DW-1:0]    rf_d_in,
  output logic [NREGS-1:0] busy,
  output logic             err_wb
);
  logic [1:0]       gnt;
  logic             wb_acc;
  logic             issue_fire;
  logic [NREGS-1:0] busy_nxt;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({wb1_valid, wb0_valid}),
    .advance (wb_acc),
    .gnt     (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  // A grant is only ever given to a valid requester, so any grant is an accept.
  assign wb_acc    = |gnt;

  assign issue_ready = !(busy[issue_dst] | busy[issue_src_a] | busy[issue_src_b]);
  assign issue_fire  = issue_valid && issue_ready;

  // Clear lands on the same edge the file is written; the issue stall keeps
  // a set and a clear of the same bit from ever coinciding.
  always_comb begin
    busy_nxt = busy;
    if (rf_wr)      busy_nxt[rf_wr_addr] = 1'b0;
    if (issue_fire) busy_nxt[issue_dst]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr      <= 1'b0;
      rf_wr_addr <= '0;
      rf_d_in    <= '0;
      busy       <= '0;
      err_wb     <= 1'b0;
    end else begin
      rf_wr <= wb_acc;
      if (wb_acc) begin
        rf_wr_addr <= gnt[1] ? wb1_addr : wb0_addr;
        rf_d_in    <= gnt[1] ? wb1_data : wb0_data;
      end
      busy <= busy_nxt;
      if (rf_wr && !busy[rf_wr_addr]) err_wb <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench: expected register-file writes go into a queue that a
// negedge monitor drains whenever rf_wr is seen; other checks are inline.
module tb_rf_wb_sched;
  import rf_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           issue_valid;
  rf_addr_t       issue_dst, issue_src_a, issue_src_b;
  logic           issue_ready;
  logic           wb0_valid, wb1_valid;
  rf_addr_t       wb0_addr, wb1_addr;
  rf_data_t       wb0_data, wb1_data;
  logic           wb0_ready, wb1_ready;
  logic           rf_wr;
  rf_addr_t       rf_wr_addr;
  rf_data_t       rf_d_in;
  logic [7:0]     busy;
  logic           err_wb;

  int n_vec = 0;
  int n_bad = 0;
  logic [RF_AW+RF_DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_ready(issue_ready),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
    .busy(busy), .err_wb(err_wb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rf_wr cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_wr === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {13'd0, rf_wr_addr, rf_d_in}, 32'hFFFF_FFFF);
      else chk("write", {13'd0, rf_wr_addr, rf_d_in}, {13'd0, exp_q.pop_front()});
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic v, input rf_addr_t d, input rf_addr_t a, input rf_addr_t b);
    issue_valid = v; issue_dst = d; issue_src_a = a; issue_src_b = b;
  endtask

  initial begin
    reset = 1'b1;
    issue(1'b0, 3'd0, 3'd0, 3'd0);
    wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
    next_cyc(); next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 8'h00);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_addr", rf_wr_addr, 0);
    chk("rst_data", rf_d_in, 0);
    chk("rst_err", err_wb, 0);

    // 1: reserve r3, then a reader of r3 stalls
    next_cyc(); issue(1'b1, 3'd3, 3'd1, 3'd2);
    @(negedge clk); chk("t1_ready", issue_ready, 1);
    next_cyc(); issue(1'b1, 3'd0, 3'd3, 3'd0);
    @(negedge clk); chk("t1_busy", busy, 8'h08); chk("t1_stall", issue_ready, 0);

    // 2: writeback to r3 clears it two cycles after accept
    next_cyc(); issue(1'b0, 3'd0, 3'd3, 3'd0);
    wb0_valid = 1; wb0_addr = 3; wb0_data = 16'hBEEF; exp_q.push_back({3'd3, 16'hBEEF});
    @(negedge clk); chk("t2_gnt0", wb0_ready, 1); chk("t2_gnt1", wb1_ready, 0);
    next_cyc(); wb0_valid = 0;
    @(negedge clk); chk("t2_rfwr", rf_wr, 1); chk("t2_busy_n1", busy, 8'h08); chk("t2_stall_n1", issue_ready, 0);
    next_cyc();
    @(negedge clk); chk("t2_busy_n2", busy, 8'h00); chk("t2_ready_n2", issue_ready, 1);
    chk("t2_rfwr_n2", rf_wr, 0); chk("t2_err", err_wb, 0);

    // 4: writeback to non-busy r6 sets sticky err_wb
    next_cyc();
    wb1_valid = 1; wb1_addr = 6; wb1_data = 16'h1234; exp_q.push_back({3'd6, 16'h1234});
    @(negedge clk); chk("t4_gnt1", wb1_ready, 1); chk("t4_gnt0", wb0_ready, 0);
    next_cyc(); wb1_valid = 0;
    @(negedge clk); chk("t4_err_n1", err_wb, 0); chk("t4_busy_n1", busy, 8'h00);
    next_cyc();
    @(negedge clk); chk("t4_err_n2", err_wb, 1); chk("t4_busy_n2", busy, 8'h00);
    next_cyc();
    @(negedge clk); chk("t4_err_hold", err_wb, 1);

    // 3: reserve r4/r5, then continuous contention alternates starting with wb0
    next_cyc(); issue(1'b1, 3'd4, 3'd4, 3'd4);
    @(negedge clk); chk("t3_res4", issue_ready, 1);
    next_cyc(); issue(1'b1, 3'd5, 3'd5, 3'd5);
    @(negedge clk); chk("t3_res5", issue_ready, 1); chk("t3_busy4", busy, 8'h10);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      issue(1'b0, 3'd0, 3'd0, 3'd0);
      wb0_valid = 1; wb0_addr = 4; wb0_data = 16'hA001 + 16'((i + 1) >> 1);
      wb1_valid = 1; wb1_addr = 5; wb1_data = 16'hB001 + 16'(i >> 1);
      if (i % 2 == 0) exp_q.push_back({3'd4, wb0_data});
      else            exp_q.push_back({3'd5, wb1_data});
      @(negedge clk);
      chk("t3_gnt0", wb0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t3_gnt1", wb1_ready, (i % 2 == 1) ? 1 : 0);
      if (i > 0) chk("t3_rfwr_cont", rf_wr, 1);
    end
    next_cyc(); wb0_valid = 0; wb1_valid = 0;
    @(negedge clk); chk("t3_rfwr_last", rf_wr, 1);
    next_cyc();
    @(negedge clk); chk("t3_rfwr_off", rf_wr, 0); chk("t3_busy_clr", busy, 8'h00);

    // 5: reset during the rf_wr cycle
    next_cyc(); issue(1'b1, 3'd2, 3'd2, 3'd2);
    @(negedge clk); chk("t5_res2", issue_ready, 1);
    next_cyc(); issue(1'b0, 3'd0, 3'd0, 3'd0);
    wb0_valid = 1; wb0_addr = 2; wb0_data = 16'h2222; exp_q.push_back({3'd2, 16'h2222});
    @(negedge clk); chk("t5_gnt0", wb0_ready, 1); chk("t5_busy", busy, 8'h04);
    next_cyc(); wb0_valid = 0; reset = 1;
    @(negedge clk); chk("t5_rfwr", rf_wr, 1);
    next_cyc(); reset = 0;
    @(negedge clk); chk("t5_rfwr_rst", rf_wr, 0); chk("t5_busy_rst", busy, 8'h00); chk("t5_err_rst", err_wb, 0);
    next_cyc();
    wb0_valid = 1; wb0_addr = 0; wb0_data = 16'h0A0A;
    wb1_valid = 1; wb1_addr = 1; wb1_data = 16'h1B1B; exp_q.push_back({3'd0, 16'h0A0A});
    @(negedge clk); chk("t5_first_gnt0", wb0_ready, 1); chk("t5_first_gnt1", wb1_ready, 0);
    next_cyc(); wb0_valid = 0; wb1_valid = 0;

    // 6: issue sets r7 on the same edge the scoreboard clears r5
    next_cyc(); issue(1'b1, 3'd5, 3'd5, 3'd5);
    next_cyc(); issue(1'b0, 3'd0, 3'd0, 3'd0);
    wb1_valid = 1; wb1_addr = 5; wb1_data = 16'h5555; exp_q.push_back({3'd5, 16'h5555});
    @(negedge clk); chk("t6_gnt1", wb1_ready, 1);
    next_cyc(); wb1_valid = 0; issue(1'b1, 3'd7, 3'd0, 3'd1);
    @(negedge clk); chk("t6_busy_pre", busy, 8'h20); chk("t6_ready", issue_ready, 1);
    next_cyc(); issue(1'b0, 3'd7, 3'd0, 3'd1);
    @(negedge clk); chk("t6_busy_post", busy, 8'h80); chk("t6_stall7", issue_ready, 0);

    next_cyc(); next_cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
